// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: decode-stage operand bypass selects, load-use stalls and branch flushes.
// Define HAZ_PERF_CNT_EN to add the saturating stall_cnt_o / flush_cnt_o counters.
module hazard_forward_ctrl #(
    parameter logic [1:0] MEM_DATA     = 2'b10,
    parameter int         STALL_CYCLES = 1,
    parameter int         FLUSH_EXTRA  = 0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_rs1_used_i,
    input  logic        id_rs2_used_i,
    input  logic        id_we_i,
    input  logic [4:0]  id_rd_i,
    input  logic [1:0]  id_wd_sel_i,
    input  logic        br_taken_i,
    output logic [1:0]  fwd1_src_o,
    output logic [1:0]  fwd2_src_o,
    output logic        r1_select_o,
    output logic        r2_select_o,
    output logic        stall_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    typedef struct packed {
        logic       v;
        logic       we;
        logic [4:0] rd;
        logic       ld;
    } rec_t;

    typedef enum logic [1:0] {IDLE, STALL, FLUSH} state_t;

    localparam logic [2:0] STALL_LD = 3'(STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_LD = 3'(FLUSH_EXTRA);

    rec_t       ex_q, mem_q, wb_q;
    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       hazard;

    function automatic logic hit(rec_t r, logic [4:0] rs, logic used);
        return r.v & r.we & (r.rd == rs) & (rs != 5'd0) & used;
    endfunction

    // A load still in EX has no data yet, so it blocks older matches rather than falling through.
    function automatic logic [1:0] fwd(rec_t e, rec_t m, rec_t w, logic [4:0] rs, logic used);
        return hit(e, rs, used) ? (e.ld ? 2'b00 : 2'b01) :
               hit(m, rs, used) ? 2'b10 :
               hit(w, rs, used) ? 2'b11 : 2'b00;
    endfunction

    assign fwd1_src_o  = id_valid_i ? fwd(ex_q, mem_q, wb_q, id_rs1_i, id_rs1_used_i) : 2'b00;
    assign fwd2_src_o  = id_valid_i ? fwd(ex_q, mem_q, wb_q, id_rs2_i, id_rs2_used_i) : 2'b00;
    assign r1_select_o = |fwd1_src_o;
    assign r2_select_o = |fwd2_src_o;
    assign hazard      = id_valid_i & ex_q.ld &
                         (hit(ex_q, id_rs1_i, id_rs1_used_i) | hit(ex_q, id_rs2_i, id_rs2_used_i));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stall_o       = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        // A taken branch wins everywhere: starts, aborts a stall, or reloads a flush.
        if (br_taken_i) begin
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            state_d       = (FLUSH_EXTRA > 0) ? FLUSH : IDLE;
            cnt_d         = (FLUSH_EXTRA > 0) ? FLUSH_LD : 3'd0;
        end else if (state_q == STALL) begin
            stall_o       = 1'b1;
            flush_id_ex_o = 1'b1;
            cnt_d         = cnt_q - 3'd1;
            state_d       = (cnt_q == 3'd1) ? IDLE : STALL;
        end else if (state_q == FLUSH) begin
            flush_if_id_o = 1'b1;
            cnt_d         = cnt_q - 3'd1;
            state_d       = (cnt_q == 3'd1) ? IDLE : FLUSH;
        end else if (hazard) begin
            stall_o       = 1'b1;
            flush_id_ex_o = 1'b1;
            state_d       = (STALL_CYCLES > 1) ? STALL : IDLE;
            cnt_d         = (STALL_CYCLES > 1) ? STALL_LD : 3'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wb_q    <= mem_q;
            mem_q   <= ex_q;
            ex_q    <= (stall_o | flush_id_ex_o | !id_valid_i) ? '0 :
                       {1'b1, id_we_i, id_rd_i, id_wd_sel_i == MEM_DATA};
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_o <= 32'd0;
            flush_cnt_o <= 32'd0;
        end else begin
            if (stall_o && stall_cnt_o != 32'hFFFF_FFFF) stall_cnt_o <= stall_cnt_o + 32'd1;
            if (br_taken_i && flush_cnt_o != 32'hFFFF_FFFF) flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: drives a base instance (STALL_CYCLES=1, FLUSH_EXTRA=0) and a configured
// instance (STALL_CYCLES=3, FLUSH_EXTRA=2) from shared inputs; expectations are queued per cycle.
module tb_hazard_forward_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       v, u1, u2, we, br;
    logic [4:0] rs1, rs2, rd;
    logic [1:0] ws;
    logic [1:0] f1 [2];
    logic [1:0] f2 [2];
    logic       r1 [2];
    logic       r2 [2];
    logic       st [2];
    logic       fif [2];
    logic       fex [2];
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] sc [2];
    logic [31:0] fc [2];
`endif

    typedef struct {
        string      tag;
        int         idx;
        logic [8:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < 2; g++) begin : g_dut
        hazard_forward_ctrl #(
            .STALL_CYCLES(g ? 3 : 1),
            .FLUSH_EXTRA (g ? 2 : 0)
        ) u_dut (
            .clk_i        (clk),
            .reset_i      (rst),
            .id_valid_i   (v),
            .id_rs1_i     (rs1),
            .id_rs2_i     (rs2),
            .id_rs1_used_i(u1),
            .id_rs2_used_i(u2),
            .id_we_i      (we),
            .id_rd_i      (rd),
            .id_wd_sel_i  (ws),
            .br_taken_i   (br),
            .fwd1_src_o   (f1[g]),
            .fwd2_src_o   (f2[g]),
            .r1_select_o  (r1[g]),
            .r2_select_o  (r2[g]),
            .stall_o      (st[g]),
            .flush_if_id_o(fif[g]),
            .flush_id_ex_o(fex[g])
`ifdef HAZ_PERF_CNT_EN
            ,
            .stall_cnt_o  (sc[g]),
            .flush_cnt_o  (fc[g])
`endif
        );
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] outs(int i);
        return {f1[i], f2[i], r1[i], r2[i], st[i], fif[i], fex[i]};
    endfunction

    // Expected output bundle; selects follow from a nonzero source.
    function automatic logic [8:0] e(logic [1:0] a, logic [1:0] b, logic s, logic fi, logic fe);
        return {a, b, a != 2'b00, b != 2'b00, s, fi, fe};
    endfunction

    task automatic want(string tag, int i, logic [8:0] x);
        sb_t s;
        s.tag = tag;
        s.idx = i;
        s.exp = x;
        sb.push_back(s);
    endtask

    task automatic both(string tag, logic [8:0] x);
        want({tag, "/base"}, 0, x);
        want({tag, "/cfg"}, 1, x);
    endtask

    task automatic drv(logic iv, logic [4:0] a, logic [4:0] b, logic ua, logic ub,
                       logic w, logic [4:0] d, logic [1:0] s, logic bt);
        v   = iv;
        rs1 = a;
        rs2 = b;
        u1  = ua;
        u2  = ub;
        we  = w;
        rd  = d;
        ws  = s;
        br  = bt;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0);
    endtask

    task automatic tick();
        @(negedge clk);
        while (sb.size() > 0) begin
            sb_t x;
            x = sb.pop_front();
            check(x.tag, 32'(outs(x.idx)), 32'(x.exp));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        both("rst_out", 9'd0);
`ifdef HAZ_PERF_CNT_EN
        check("rst_scnt", sc[1], 32'd0);
        check("rst_fcnt", fc[1], 32'd0);
`endif
        tick();
        drv(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 5'd0, 2'b00, 1'b0);
        both("rst_rec", 9'd0);
        tick();
        // ALU result forwarded from EX, then MEM, then WB
        drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 2'b00, 1'b0);
        both("x5_w", 9'd0);
        tick();
        drv(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 1'b1, 5'd8, 2'b00, 1'b0);
        both("fwd_ex", e(2'b01, 2'b00, 1'b0, 1'b0, 1'b0));
        tick();
        drv(1'b1, 5'd8, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 2'b00, 1'b0);
        both("fwd_mem", e(2'b01, 2'b10, 1'b0, 1'b0, 1'b0));
        tick();
        drv(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 2'b00, 1'b0);
        both("fwd_wb", e(2'b11, 2'b00, 1'b0, 1'b0, 1'b0));
        tick();
        // Load-use: one stall cycle on base, three on cfg
        do_reset();
        drv(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 2'b10, 1'b0);
        both("lw", 9'd0);
        tick();
        drv(1'b1, 5'd0, 5'd6, 1'b0, 1'b1, 1'b1, 5'd9, 2'b00, 1'b0);
        both("lu1", e(2'b00, 2'b00, 1'b1, 1'b0, 1'b1));
        tick();
        want("lu2/base", 0, e(2'b00, 2'b10, 1'b0, 1'b0, 1'b0));
        want("lu2/cfg", 1, e(2'b00, 2'b10, 1'b1, 1'b0, 1'b1));
        tick();
        want("lu3/base", 0, e(2'b00, 2'b11, 1'b0, 1'b0, 1'b0));
        want("lu3/cfg", 1, e(2'b00, 2'b11, 1'b1, 1'b0, 1'b1));
        tick();
        both("lu4", 9'd0);
`ifdef HAZ_PERF_CNT_EN
        check("scnt_cfg", sc[1], 32'd3);
        check("scnt_base", sc[0], 32'd1);
`endif
        tick();
        // x0 never matches; youngest writer wins
        do_reset();
        drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 2'b00, 1'b0);
        tick();
        drv(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 2'b00, 1'b0);
        both("x0_rd", 9'd0);
        tick();
        drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 2'b00, 1'b0);
        tick();
        drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd10, 2'b00, 1'b0);
        tick();
        drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 2'b00, 1'b0);
        tick();
        drv(1'b1, 5'd7, 5'd10, 1'b1, 1'b1, 1'b0, 5'd0, 2'b00, 1'b0);
        both("youngest", e(2'b01, 2'b10, 1'b0, 1'b0, 1'b0));
        tick();
        // Branch beats load-use; cfg keeps flushing IF/ID two more cycles
        do_reset();
        drv(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 2'b10, 1'b0);
        tick();
        drv(1'b1, 5'd0, 5'd6, 1'b0, 1'b1, 1'b1, 5'd9, 2'b00, 1'b1);
        both("br_lu", e(2'b00, 2'b00, 1'b0, 1'b1, 1'b1));
        tick();
        idle();
        want("br1/base", 0, 9'd0);
        want("br1/cfg", 1, e(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        tick();
        want("br2/cfg", 1, e(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        tick();
        want("br3/cfg", 1, 9'd0);
        tick();
        // Branch during FLUSH reloads the counter
        drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b1);
        both("rb1", e(2'b00, 2'b00, 1'b0, 1'b1, 1'b1));
        tick();
        idle();
        want("rb2/base", 0, 9'd0);
        want("rb2/cfg", 1, e(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        tick();
        drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b1);
        both("rb3", e(2'b00, 2'b00, 1'b0, 1'b1, 1'b1));
        tick();
        idle();
        want("rb4/base", 0, 9'd0);
        want("rb4/cfg", 1, e(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        tick();
        want("rb5/cfg", 1, e(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        tick();
        want("rb6/cfg", 1, 9'd0);
`ifdef HAZ_PERF_CNT_EN
        check("fcnt_cfg", fc[1], 32'd3);
`endif
        tick();
        // Reset in the middle of a three-cycle stall
        do_reset();
        drv(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 2'b10, 1'b0);
        tick();
        drv(1'b1, 5'd0, 5'd6, 1'b0, 1'b1, 1'b1, 5'd9, 2'b00, 1'b0);
        want("rs1/cfg", 1, e(2'b00, 2'b00, 1'b1, 1'b0, 1'b1));
        tick();
        rst = 1'b1;
        want("rs2/cfg", 1, e(2'b00, 2'b10, 1'b1, 1'b0, 1'b1));
        tick();
        rst = 1'b0;
        idle();
        both("rs3", 9'd0);
`ifdef HAZ_PERF_CNT_EN
        check("rs_scnt", sc[1], 32'd0);
`endif
        tick();
        // Branch aborts a stall in progress
        drv(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 2'b10, 1'b0);
        tick();
        drv(1'b1, 5'd0, 5'd6, 1'b0, 1'b1, 1'b1, 5'd9, 2'b00, 1'b0);
        want("ab1/cfg", 1, e(2'b00, 2'b00, 1'b1, 1'b0, 1'b1));
        tick();
        br = 1'b1;
        want("ab2/cfg", 1, e(2'b00, 2'b10, 1'b0, 1'b1, 1'b1));
        tick();
        idle();
        want("ab3/cfg", 1, e(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        tick();
        want("ab4/cfg", 1, e(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        tick();
        want("ab5/cfg", 1, 9'd0);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
